// File: rtl/fwd_hazard_unit_pkg.sv
// Shared types for the forwarding/hazard unit: scoreboard entry, select encoding, FSM states.
package fwd_pkg;

  localparam int unsigned FWD_REG_AW          = 5;
  localparam int unsigned NUM_FWD_STAGES_DFLT = 2;
  localparam int unsigned FWD_SEL_W           = $clog2(NUM_FWD_STAGES_DFLT + 1);
  localparam int unsigned SEL_RF              = 0;

  typedef struct packed {
    logic                  valid;
    logic [FWD_REG_AW-1:0] rd;
    logic                  we;
    logic                  is_load;
  } sb_entry_t;

  typedef enum logic {
    RUN   = 1'b0,
    STALL = 1'b1
  } fwd_state_e;

endpackage

// File: rtl/fwd_port_mux.sv
// One source operand: match against in-flight producers, youngest wins, select data.
module fwd_port_mux
  import fwd_pkg::*;
#(
  parameter int unsigned XLEN           = 32,
  parameter int unsigned NUM_FWD_STAGES = 2,
  parameter int unsigned LOAD_LAT       = 1,
  parameter int unsigned REG_AW         = 5,
  localparam int unsigned SEL_W         = $clog2(NUM_FWD_STAGES + 1)
) (
  input  sb_entry_t [NUM_FWD_STAGES-1:0] sb,
  input  logic [REG_AW-1:0]              rs_addr,
  input  logic [XLEN-1:0]                rs_data,
  input  logic [NUM_FWD_STAGES*XLEN-1:0] stg_data,
  output logic [XLEN-1:0]                data_c,
  output logic [SEL_W-1:0]               sel_c,
  output logic                           load_use_c
);

  // Walk oldest to youngest so the lowest-index match is the final assignment.
  always_comb begin
    data_c     = rs_data;
    sel_c      = SEL_W'(SEL_RF);
    load_use_c = 1'b0;
    for (int k = int'(NUM_FWD_STAGES) - 1; k >= 0; k--) begin
      if (sb[k].valid && sb[k].we && (sb[k].rd == FWD_REG_AW'(rs_addr)) &&
          (rs_addr != '0)) begin
        data_c     = stg_data[k*XLEN +: XLEN];
        sel_c      = SEL_W'(k + 1);
        load_use_c = sb[k].is_load && (k < int'(LOAD_LAT));
      end
    end
  end

endmodule

// File: rtl/fwd_hazard_unit.sv
// Operand forwarding and load-use stall unit; FWD_PERF_CNT_EN adds stall/forward counters.
module fwd_hazard_unit
  import fwd_pkg::*;
#(
  parameter int unsigned XLEN           = 32,
  parameter int unsigned NUM_RD_PORTS   = 2,
  parameter int unsigned NUM_FWD_STAGES = 2,
  parameter int unsigned LOAD_LAT       = 1,
  parameter int unsigned REG_AW         = 5,
  localparam int unsigned SEL_W         = $clog2(NUM_FWD_STAGES + 1)
) (
  input  logic                            clk,
  input  logic                            rstn,
  input  logic                            flush,
  input  logic                            id_valid,
  input  logic [NUM_RD_PORTS*REG_AW-1:0]  id_rs_addr,
  input  logic [NUM_RD_PORTS*XLEN-1:0]    id_rs_data,
  input  logic [REG_AW-1:0]               id_rd_addr,
  input  logic                            id_rd_we,
  input  logic                            id_is_load,
  input  logic [NUM_FWD_STAGES*XLEN-1:0]  stg_data,
  output logic [NUM_RD_PORTS*XLEN-1:0]    fwd_rs_data,
  output logic [NUM_RD_PORTS*SEL_W-1:0]   fwd_sel,
  output logic                            stall
`ifdef FWD_PERF_CNT_EN
  ,
  output logic [31:0]                     perf_stall_cnt,
  output logic [31:0]                     perf_fwd_cnt
`endif
);

  sb_entry_t [NUM_FWD_STAGES-1:0] sb_q;
  fwd_state_e                     state_q, state_d;
  logic [NUM_RD_PORTS*XLEN-1:0]   mux_data;
  logic [NUM_RD_PORTS*SEL_W-1:0]  mux_sel;
  logic [NUM_RD_PORTS-1:0]        port_load_use;
  logic                           hazard_c;
  logic                           stall_c;

  for (genvar p = 0; p < int'(NUM_RD_PORTS); p++) begin : g_port
    fwd_port_mux #(
      .XLEN           (XLEN),
      .NUM_FWD_STAGES (NUM_FWD_STAGES),
      .LOAD_LAT       (LOAD_LAT),
      .REG_AW         (REG_AW)
    ) u_mux (
      .sb         (sb_q),
      .rs_addr    (id_rs_addr[p*REG_AW +: REG_AW]),
      .rs_data    (id_rs_data[p*XLEN +: XLEN]),
      .stg_data   (stg_data),
      .data_c     (mux_data[p*XLEN +: XLEN]),
      .sel_c      (mux_sel[p*SEL_W +: SEL_W]),
      .load_use_c (port_load_use[p])
    );
  end

  assign hazard_c = id_valid && (|port_load_use);

  // Scoreboard pipe; a stalled or flushed decode slot enters as a bubble.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      sb_q <= '0;
    end else if (flush) begin
      sb_q <= '0;
    end else begin
      sb_q[0] <= '{valid:   id_valid && !stall_c,
                   rd:      FWD_REG_AW'(id_rd_addr),
                   we:      id_rd_we,
                   is_load: id_is_load};
      for (int k = 1; k < int'(NUM_FWD_STAGES); k++) begin
        sb_q[k] <= sb_q[k-1];
      end
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) state_q <= RUN;
    else       state_q <= state_d;
  end

  // Hazards age out as the load moves down the pipe, so STALL is self-limiting.
  always_comb begin
    state_d = state_q;
    stall_c = 1'b0;
    unique case (state_q)
      RUN: begin
        if (hazard_c && !flush) begin
          state_d = STALL;
          stall_c = 1'b1;
        end
      end
      STALL: begin
        if (flush || !hazard_c) state_d = RUN;
        else                    stall_c = 1'b1;
      end
      default: state_d = RUN;
    endcase
  end

  // Zero latency path, forced to zero while reset is held.
  assign fwd_rs_data = rstn ? mux_data : '0;
  assign fwd_sel     = rstn ? mux_sel  : '0;
  assign stall       = rstn && stall_c;

`ifdef FWD_PERF_CNT_EN
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      perf_stall_cnt <= '0;
      perf_fwd_cnt   <= '0;
    end else begin
      if (stall_c && (perf_stall_cnt != '1))
        perf_stall_cnt <= perf_stall_cnt + 32'd1;
      if (id_valid && !stall_c && (|mux_sel) && (perf_fwd_cnt != '1))
        perf_fwd_cnt <= perf_fwd_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_fwd_hazard_unit.sv
// Directed bench for fwd_hazard_unit: forwarding priority, x0, load-use stall, flush, reset.
module tb_fwd_hazard_unit;

  localparam int unsigned XLEN  = 32;
  localparam int unsigned NP    = 2;
  localparam int unsigned NS    = 2;
  localparam int unsigned AW    = 5;
  localparam int unsigned SEL_W = 2;

  logic                 clk = 1'b0;
  logic                 rstn;
  logic                 flush;
  logic                 id_valid;
  logic [NP*AW-1:0]     id_rs_addr;
  logic [NP*XLEN-1:0]   id_rs_data;
  logic [AW-1:0]        id_rd_addr;
  logic                 id_rd_we;
  logic                 id_is_load;
  logic [NS*XLEN-1:0]   stg_data;
  logic [NP*XLEN-1:0]   fwd_rs_data;
  logic [NP*SEL_W-1:0]  fwd_sel;
  logic                 stall;
`ifdef FWD_PERF_CNT_EN
  logic [31:0]          perf_stall_cnt;
  logic [31:0]          perf_fwd_cnt;
`endif

  int checks   = 0;
  int failures = 0;

  fwd_hazard_unit dut (
    .clk         (clk),
    .rstn        (rstn),
    .flush       (flush),
    .id_valid    (id_valid),
    .id_rs_addr  (id_rs_addr),
    .id_rs_data  (id_rs_data),
    .id_rd_addr  (id_rd_addr),
    .id_rd_we    (id_rd_we),
    .id_is_load  (id_is_load),
    .stg_data    (stg_data),
    .fwd_rs_data (fwd_rs_data),
    .fwd_sel     (fwd_sel),
    .stall       (stall)
`ifdef FWD_PERF_CNT_EN
    ,
    .perf_stall_cnt (perf_stall_cnt),
    .perf_fwd_cnt   (perf_fwd_cnt)
`endif
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic issue(input logic v, input logic [AW-1:0] rs1, input logic [AW-1:0] rs2,
                       input logic [31:0] d1, input logic [31:0] d2,
                       input logic [AW-1:0] rd, input logic we, input logic ld);
    id_valid   = v;
    id_rs_addr = {rs2, rs1};
    id_rs_data = {d2, d1};
    id_rd_addr = rd;
    id_rd_we   = we;
    id_is_load = ld;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] sel_of(input int p);
    return 32'(fwd_sel[p*SEL_W +: SEL_W]);
  endfunction

  function automatic logic [31:0] dat_of(input int p);
    return fwd_rs_data[p*XLEN +: XLEN];
  endfunction

  initial begin
    rstn     = 1'b0;
    flush    = 1'b0;
    stg_data = {32'h9999, 32'h1234};
    issue(1'b1, 5'd5, 5'd3, 32'h5555, 32'h6666, 5'd0, 1'b0, 1'b0);
    #12;
    check("rst_sel0",  sel_of(0), 32'd0);
    check("rst_data0", dat_of(0), 32'h0);
    check("rst_data1", dat_of(1), 32'h0);
    check("rst_stall", 32'(stall), 32'd0);
`ifdef FWD_PERF_CNT_EN
    check("rst_pstall", perf_stall_cnt, 32'd0);
    check("rst_pfwd",   perf_fwd_cnt,   32'd0);
`endif
    tick();
    rstn = 1'b1;

    // A: ADD x5
    issue(1'b1, 5'd0, 5'd0, 32'h0, 32'h0, 5'd5, 1'b1, 1'b0);
    tick();
    // B: ADD x5, x5, x3 -- reads x5 from entry 0
    stg_data = {32'h9999, 32'h1234};
    issue(1'b1, 5'd5, 5'd3, 32'h11, 32'h22, 5'd5, 1'b1, 1'b0);
    #1;
    check("fwd_e0_sel0",  sel_of(0), 32'd1);
    check("fwd_e0_data0", dat_of(0), 32'h1234);
    check("fwd_rf_sel1",  sel_of(1), 32'd0);
    check("fwd_rf_data1", dat_of(1), 32'h22);
    check("fwd_e0_stall", 32'(stall), 32'd0);
    tick();
    // C: x5 in entries 0 and 1, youngest wins on port 1
    stg_data = {32'hBBBB, 32'hAAAA};
    issue(1'b1, 5'd3, 5'd5, 32'h33, 32'h44, 5'd0, 1'b0, 1'b0);
    #1;
    check("prio_sel1",  sel_of(1), 32'd1);
    check("prio_data1", dat_of(1), 32'hAAAA);
    check("prio_data0", dat_of(0), 32'h33);
    tick();
    // D: LW x7, also reads x5 now only in entry 1
    issue(1'b1, 5'd0, 5'd5, 32'h0, 32'h55, 5'd7, 1'b1, 1'b1);
    #1;
    check("e1_sel1",  sel_of(1), 32'd2);
    check("e1_data1", dat_of(1), 32'hBBBB);
    tick();
    // E: reader of x7 right behind the load
    stg_data = {32'hD0D0, 32'hC0C0};
    issue(1'b1, 5'd7, 5'd0, 32'h77, 32'h0, 5'd0, 1'b0, 1'b0);
    #1;
    check("lu_stall",  32'(stall), 32'd1);
    check("lu_sel0",   sel_of(0), 32'd1);
    tick();
    #1;
    check("lu_stall_1cyc", 32'(stall), 32'd0);
    check("lu_sel0_e1",    sel_of(0), 32'd2);
    check("lu_data0_e1",   dat_of(0), 32'hD0D0);
    tick();
    // F: write to x0
    issue(1'b1, 5'd0, 5'd0, 32'h0, 32'h0, 5'd0, 1'b1, 1'b0);
    tick();
    stg_data = {32'h0, 32'hFFFF};
    issue(1'b1, 5'd0, 5'd0, 32'h0, 32'h0, 5'd0, 1'b0, 1'b0);
    #1;
    check("x0_sel0",  sel_of(0), 32'd0);
    check("x0_data0", dat_of(0), 32'h0);
    tick();
    // Flush during load-use stall
    issue(1'b1, 5'd0, 5'd0, 32'h0, 32'h0, 5'd7, 1'b1, 1'b1);
    tick();
    issue(1'b1, 5'd7, 5'd0, 32'h7777, 32'h0, 5'd0, 1'b0, 1'b0);
    #1;
    check("fl_pre_stall", 32'(stall), 32'd1);
    flush = 1'b1;
    #1;
    check("fl_stall", 32'(stall), 32'd0);
    tick();
    flush = 1'b0;
    #1;
    check("fl_sel0",  sel_of(0), 32'd0);
    check("fl_data0", dat_of(0), 32'h7777);
    check("fl_stall_after", 32'(stall), 32'd0);
    // Reset in the middle of a stall
    issue(1'b1, 5'd0, 5'd0, 32'h0, 32'h0, 5'd7, 1'b1, 1'b1);
    tick();
    issue(1'b1, 5'd7, 5'd0, 32'h4242, 32'h0, 5'd0, 1'b0, 1'b0);
    #1;
    check("rs_pre_stall", 32'(stall), 32'd1);
    rstn = 1'b0;
    #1;
    check("rs_stall", 32'(stall), 32'd0);
    check("rs_sel0",  sel_of(0), 32'd0);
    check("rs_data0", dat_of(0), 32'h0);
`ifdef FWD_PERF_CNT_EN
    check("rs_pstall", perf_stall_cnt, 32'd0);
    check("rs_pfwd",   perf_fwd_cnt,   32'd0);
`endif
    tick();
    rstn = 1'b1;
    #1;
    check("rs_post_sel0",  sel_of(0), 32'd0);
    check("rs_post_data0", dat_of(0), 32'h4242);
    check("rs_post_stall", 32'(stall), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/fwd_hazard_unit.md
Name: fwd_hazard_unit

Overview:
- Parametrised successor to the core's ALU/WB forwarding unit.
- Tracks in-flight destination registers across NUM_FWD_STAGES pipeline stages in an internal scoreboard pipe.
- Selects forwarded operands for NUM_RD_PORTS source operands, with youngest-producer priority.
- Detects load-use hazards, stalls issue until load data is forwardable, and handles flush.

Parameters:
- XLEN, 32, datapath width.
- NUM_RD_PORTS, 2, source operands forwarded per instruction.
- NUM_FWD_STAGES, 2, tracked stages after decode (entry 0 = EX, last = WB).
- LOAD_LAT, 1, first stage index where load data is valid; must be < NUM_FWD_STAGES.
- REG_AW, 5, register address width.

Ports:
- clk  in  1  clock
- rstn  in  1  reset, asynchronous, active-low
- flush  in  1  kill all tracked entries (branch mispredict)
- id_valid  in  1  decode holds a valid instruction
- id_rs_addr  in  NUM_RD_PORTS*REG_AW  source register addresses, port p at [p*REG_AW +: REG_AW]
- id_rs_data  in  NUM_RD_PORTS*XLEN  register-file read data
- id_rd_addr  in  REG_AW  destination of the decoding instruction
- id_rd_we  in  1  decoding instruction writes rd
- id_is_load  in  1  decoding instruction is a load
- stg_data  in  NUM_FWD_STAGES*XLEN  result currently held by stage k
- fwd_rs_data  out  NUM_RD_PORTS*XLEN  forwarded operands to execute
- fwd_sel  out  NUM_RD_PORTS*$clog2(NUM_FWD_STAGES+1)  per-port source: 0 = register file, k+1 = stage k
- stall  out  1  hold fetch/decode this cycle

Behaviour:
- Reset (async, rstn=0):
  - all scoreboard entries invalid, FSM = RUN.
  - fwd_rs_data = 0, fwd_sel = 0, stall = 0; all hold these values while rstn is low.
- Scoreboard entry fields: valid, rd, we, is_load.
- Every clock, entry k moves to k+1 and the last entry retires.
- Entry 0 loads {id_valid & ~stall, id_rd_addr, id_rd_we, id_is_load}; a stall cycle therefore injects a bubble.
- Match for port p at entry k: valid & we & rd == rs_addr[p] & rs_addr[p] != 0. Register x0 is never forwarded.
- Priority: lowest k wins, so the youngest producer supplies the operand.
  - No match: fwd_sel = 0, data = id_rs_data.
  - Match at k: fwd_sel = k+1, data = stg_data[k].
- Forwarding path is combinational, zero latency.
- Load-use hazard: the winning match is_load with k < LOAD_LAT, and id_valid = 1.
  - stall = 1 in the same cycle (combinational).
  - fwd_sel/data still reflect the match but are ignored by execute.
- FSM:
  - RUN -> STALL on hazard.
  - STALL stays while the hazard persists; entries age each cycle, so the hazard clears after at most LOAD_LAT cycles.
  - STALL -> RUN when the hazard clears.
  - Either state -> RUN on flush.
  - stall is never asserted for more than LOAD_LAT consecutive cycles.
- Flush:
  - all entries invalid on the next edge; entry 0 also loads invalid.
  - flush overrides stall in that cycle (stall = 0).
- Simultaneous matches on multiple ports are resolved independently per port.
- One port hazarding stalls the whole instruction.
- Reset mid-stall: immediate return to RUN, entries cleared.

Optional Feature:
- Macro FWD_PERF_CNT_EN.
- When defined:
  - adds outputs perf_stall_cnt (32) and perf_fwd_cnt (32).
  - perf_stall_cnt increments on each stall cycle; perf_fwd_cnt increments on each cycle with id_valid & ~stall and any fwd_sel != 0.
  - both saturate at 0xFFFFFFFF and clear on reset.
- When undefined: ports and counters are absent; behaviour is otherwise identical.

Decomposition:
- Shared package fwd_pkg holds:
  - the sb_entry_t struct {valid, rd, we, is_load};
  - localparams FWD_SEL_W = $clog2(NUM_FWD_STAGES+1) and SEL_RF = 0;
  - the FSM enum {RUN, STALL}.
- Sub-module fwd_port_mux, instantiated once per read port: match, priority and data mux for one operand.
- The top level owns the scoreboard pipe, the FSM and the optional counters.

Test Plan:
- Defaults; ADD x5 issued, next instruction reads rs1 = x5; stg_data[0] = 0x1234 -> fwd_sel[0] = 1, fwd_rs_data[0] = 0x1234, stall = 0.
- x5 written in both entry 0 (0xAAAA) and entry 1 (0xBBBB), reader of x5 -> selects entry 0, data 0xAAAA.
- LW x7, then an instruction reading x7 -> stall = 1 for exactly 1 cycle; next cycle fwd_sel = 2 with stg_data[1].
- Instruction writes x0 (entry 0 data 0xFFFF), reader rs = x0 with id_rs_data = 0 -> fwd_sel = 0, data 0.
- Load-use stall active, flush = 1 -> stall = 0 same cycle; next cycle all entries invalid and a reader of x7 gets register-file data.
- rstn pulsed low during STALL -> outputs 0 immediately; with FWD_PERF_CNT_EN defined, counters read 0 after reset.
